// File: rtl/adc_sample_scheduler.sv
// adc_sample_scheduler: round-robin multi-channel sampler that writes each
// channel's samples into its own circular buffer on RAM port B.
// Ports: clock/reset (sync, active high), enable (run), ch_data (packed
// per-channel samples), rd_req/rd_addr/rd_ack/rd_valid/rd_data (reader
// client sharing port B), ram_we/ram_addr/ram_din/ram_dout (port B),
// wr_ptr (next slot per channel), wrap (last-entry pulse), cur_ch (next
// channel to be written).
module adc_sample_scheduler #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 12,
    parameter int DEPTH = 640,
    parameter int SAMPLE_INTERVAL = 125000,
    parameter int CNT_W = 18,
    parameter logic [NUM_CH*ADDR_W-1:0] BASE_ADDRS = {12'hC7F, 12'h801},
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic [NUM_CH*DATA_W-1:0]  ch_data,
    input  logic                      rd_req,
    input  logic [ADDR_W-1:0]         rd_addr,
    output logic                      rd_ack,
    output logic                      rd_valid,
    output logic [DATA_W-1:0]         rd_data,
    output logic                      ram_we,
    output logic [ADDR_W-1:0]         ram_addr,
    output logic [DATA_W-1:0]         ram_din,
    input  logic [DATA_W-1:0]         ram_dout,
    output logic [NUM_CH*PTR_W-1:0]   wr_ptr,
    output logic [NUM_CH-1:0]         wrap,
    output logic [CH_W-1:0]           cur_ch
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        WRITE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_INTERVAL - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(NUM_CH - 1);

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [DATA_W-1:0]   sample;
    logic [PTR_W-1:0]    ptr_q [NUM_CH];
    logic [CH_W-1:0]     ch_q;
    logic                rd_valid_q;

    logic [ADDR_W-1:0]   base_a [NUM_CH];
    logic [DATA_W-1:0]   data_a [NUM_CH];

    logic                in_write;
    logic                we;
    logic [PTR_W-1:0]    cur_ptr;
    logic [ADDR_W-1:0]   wr_addr;

    genvar g;
    generate
        for (g = 0; g < NUM_CH; g++) begin : g_ch
            assign base_a[g] = BASE_ADDRS[g*ADDR_W +: ADDR_W];
            assign data_a[g] = ch_data[g*DATA_W +: DATA_W];
            assign wr_ptr[g*PTR_W +: PTR_W] = ptr_q[g];
        end
    endgenerate

    assign in_write = (state == WRITE);
    // Reset in the write cycle must not corrupt RAM.
    assign we       = in_write && !reset;
    assign cur_ptr  = ptr_q[ch_q];
    // Address arithmetic is modulo 2^ADDR_W so buffers may straddle the top.
    assign wr_addr  = base_a[ch_q] + ADDR_W'(cur_ptr);

    assign ram_we   = we;
    assign ram_addr = we ? wr_addr : rd_addr;
    assign ram_din  = sample;
    assign rd_ack   = rd_req && !in_write && !reset;
    assign rd_valid = rd_valid_q;
    assign rd_data  = ram_dout;
    assign cur_ch   = ch_q;

    always_comb begin
        wrap = '0;
        if (we && cur_ptr == PTR_LAST) begin
            wrap[ch_q] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cnt        <= '0;
            sample     <= '0;
            ch_q       <= '0;
            rd_valid_q <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                ptr_q[i] <= '0;
            end
        end else begin
            rd_valid_q <= rd_ack;
            case (state)
                IDLE: begin
                    cnt <= '0;
                    if (enable) begin
                        state <= RUN;
                    end
                end
                RUN: begin
                    if (!enable) begin
                        // Partial interval is discarded.
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        // Capture one cycle early so the written value is
                        // immune to ch_data changes in the write cycle.
                        state  <= WRITE;
                        cnt    <= '0;
                        sample <= data_a[ch_q];
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WRITE: begin
                    ptr_q[ch_q] <= (cur_ptr == PTR_LAST) ? '0 : cur_ptr + 1'b1;
                    ch_q        <= (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
                    if (enable) begin
                        state <= RUN;
                        cnt   <= cnt + 1'b1;
                    end else begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// tb_adc_sample_scheduler: self-checking bench for adc_sample_scheduler
// with a time-schedule reference model of write slots and buffers.
module tb_adc_sample_scheduler;

    localparam int SI  = 4;
    localparam int DEP = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [63:0] ch_data = '0;
    logic        rd_req = 1'b0;
    logic [11:0] rd_addr = '0;
    logic [31:0] ram_dout = '0;

    logic        rd_ack, rd_valid, ram_we;
    logic [31:0] rd_data, ram_din;
    logic [11:0] ram_addr;
    logic [3:0]  wr_ptr;
    logic [1:0]  wrap;
    logic [0:0]  cur_ch;

    logic        rd_ack2, rd_valid2, ram_we2;
    logic [31:0] rd_data2, ram_din2;
    logic [11:0] ram_addr2;
    logic [3:0]  wr_ptr2;
    logic [1:0]  wrap2;
    logic [0:0]  cur_ch2;

    adc_sample_scheduler #(
        .NUM_CH(2), .DATA_W(32), .ADDR_W(12), .DEPTH(DEP),
        .SAMPLE_INTERVAL(SI), .CNT_W(3),
        .BASE_ADDRS({12'hC7F, 12'h801})
    ) dut (
        .clock(clock), .reset(reset), .enable(enable), .ch_data(ch_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack),
        .rd_valid(rd_valid), .rd_data(rd_data), .ram_we(ram_we),
        .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout),
        .wr_ptr(wr_ptr), .wrap(wrap), .cur_ch(cur_ch)
    );

    adc_sample_scheduler #(
        .NUM_CH(2), .DATA_W(32), .ADDR_W(12), .DEPTH(DEP),
        .SAMPLE_INTERVAL(SI), .CNT_W(3),
        .BASE_ADDRS({12'hC7F, 12'hFFE})
    ) dut2 (
        .clock(clock), .reset(reset), .enable(enable), .ch_data(ch_data),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack2),
        .rd_valid(rd_valid2), .rd_data(rd_data2), .ram_we(ram_we2),
        .ram_addr(ram_addr2), .ram_din(ram_din2), .ram_dout(ram_dout),
        .wr_ptr(wr_ptr2), .wrap(wrap2), .cur_ch(cur_ch2)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Reference model: schedule of write cycles plus buffer positions.
    int base1[2] = '{12'h801, 12'hC7F};
    int base2[2] = '{12'hFFE, 12'hC7F};
    int          cyc = 0;
    bit          started = 0;
    bit          m_idle = 1;
    int          m_wcyc = 0;
    int          m_ptr[2] = '{0, 0};
    int          m_ch = 0;
    logic [31:0] m_sample = '0;
    bit          m_prev_ack = 0;

    bit          e_isw, e_we, e_ack, e_rdv;
    logic [11:0] e_addr, e_addr2;
    logic [1:0]  e_wrap;
    logic [3:0]  e_ptr;
    logic [0:0]  e_ch;

    task automatic advance();
        if (reset) begin
            m_idle = 1;
            m_ptr = '{0, 0};
            m_ch = 0;
            m_sample = '0;
            m_prev_ack = 0;
        end else begin
            m_prev_ack = e_ack;
            if (e_isw) begin
                m_ptr[m_ch] = (m_ptr[m_ch] + 1) % DEP;
                m_ch = (m_ch + 1) % 2;
                if (enable) m_wcyc = cyc + SI;
                else m_idle = 1;
            end else if (m_idle) begin
                if (enable) begin
                    m_idle = 0;
                    m_wcyc = cyc + 1 + SI;
                end
            end else if (!enable) begin
                m_idle = 1;
            end else if (cyc + 1 == m_wcyc) begin
                m_sample = (m_ch == 1) ? ch_data[63:32] : ch_data[31:0];
            end
        end
    endtask

    task automatic step(input bit rst, input bit en, input bit req,
                        input logic [11:0] ra,
                        input logic [31:0] d0, input logic [31:0] d1);
        if (started) advance();
        @(negedge clock);
        cyc++;
        reset = rst;
        enable = en;
        rd_req = req;
        rd_addr = ra;
        ch_data = {d1, d0};
        ram_dout = $urandom;
        #1;
        e_isw = !m_idle && (cyc == m_wcyc);
        e_we = e_isw && !reset;
        e_addr = e_we ? 12'((base1[m_ch] + m_ptr[m_ch]) % 4096) : rd_addr;
        e_addr2 = e_we ? 12'((base2[m_ch] + m_ptr[m_ch]) % 4096) : rd_addr;
        e_ack = rd_req && !e_isw && !reset;
        e_rdv = m_prev_ack;
        e_wrap = '0;
        if (e_we && m_ptr[m_ch] == DEP - 1) e_wrap[m_ch] = 1'b1;
        e_ptr = {2'(m_ptr[1]), 2'(m_ptr[0])};
        e_ch = 1'(m_ch);
        started = 1;
    endtask

    function automatic bit next_is_write();
        return !m_idle && (m_wcyc == cyc + 1);
    endfunction

    task automatic test_reset();
        step(1, 0, 0, 12'h000, 32'h0, 32'h0);
        step(1, 0, 1, 12'h2A5, 32'h1, 32'h2);
        checks++;
        if (ram_we !== 1'b0) begin
            errors++; $display("FAIL reset_we got %b exp 0", ram_we);
        end
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++; $display("FAIL reset_rd_valid got %b exp 0", rd_valid);
        end
        checks++;
        if (wrap !== 2'b00) begin
            errors++; $display("FAIL reset_wrap got %b exp 00", wrap);
        end
        checks++;
        if (wr_ptr !== 4'h0) begin
            errors++; $display("FAIL reset_wr_ptr got %h exp 0", wr_ptr);
        end
        checks++;
        if (cur_ch !== 1'b0) begin
            errors++; $display("FAIL reset_cur_ch got %b exp 0", cur_ch);
        end
        checks++;
        if (ram_din !== 32'h0) begin
            errors++; $display("FAIL reset_din got %h exp 0", ram_din);
        end
        checks++;
        if (rd_ack !== 1'b0) begin
            errors++; $display("FAIL reset_rd_ack got %b exp 0", rd_ack);
        end
        checks++;
        if (ram_addr !== 12'h2A5) begin
            errors++; $display("FAIL reset_addr got %h exp 2a5", ram_addr);
        end
    endtask

    task automatic test_first_write();
        int wn = 0;
        int off[2] = '{-1, -1};
        logic [11:0] a[2] = '{12'h0, 12'h0};
        logic [31:0] d[2] = '{32'h0, 32'h0};
        for (int i = 0; i < 12; i++) begin
            step(0, 1, 0, 12'h0, 32'hA, 32'hB);
            if (ram_we && wn < 2) begin
                off[wn] = i; a[wn] = ram_addr; d[wn] = ram_din; wn++;
            end
        end
        checks++;
        if (wn != 2) begin
            errors++; $display("FAIL first_count got %0d exp 2", wn);
        end
        checks++;
        if (off[0] != 5) begin
            errors++; $display("FAIL first_offset got %0d exp 5", off[0]);
        end
        checks++;
        if (a[0] !== 12'h801 || d[0] !== 32'hA) begin
            errors++;
            $display("FAIL first_wr got %h/%h exp 801/a", a[0], d[0]);
        end
        checks++;
        if (off[1] != 9) begin
            errors++; $display("FAIL second_offset got %0d exp 9", off[1]);
        end
        checks++;
        if (a[1] !== 12'hC7F || d[1] !== 32'hB) begin
            errors++;
            $display("FAIL second_wr got %h/%h exp c7f/b", a[1], d[1]);
        end
    endtask

    task automatic test_wrap();
        logic [11:0] ea[7] = '{12'h801, 12'hC7F, 12'h802, 12'hC80,
                               12'h803, 12'hC81, 12'h801};
        logic [1:0]  ew[7] = '{2'b00, 2'b00, 2'b00, 2'b00,
                               2'b01, 2'b10, 2'b00};
        logic [11:0] ga[7];
        logic [1:0]  gw[7];
        int wn = 0;
        bit chk_next = 0;
        step(1, 0, 0, 12'h0, 32'h0, 32'h0);
        for (int i = 0; i < 40 && wn < 7; i++) begin
            step(0, 1, 0, 12'h0, $urandom, $urandom);
            if (chk_next) begin
                chk_next = 0;
                checks++;
                if (wr_ptr[1:0] !== 2'd0) begin
                    errors++;
                    $display("FAIL wrap_ptr0 got %0d exp 0", wr_ptr[1:0]);
                end
            end
            if (!ram_we && wrap !== 2'b00) begin
                checks++;
                errors++; $display("FAIL wrap_idle got %b exp 00", wrap);
            end
            if (ram_we) begin
                ga[wn] = ram_addr; gw[wn] = wrap;
                if (wn == 4) chk_next = 1;
                wn++;
            end
        end
        checks++;
        if (wn != 7) begin
            errors++; $display("FAIL wrap_count got %0d exp 7", wn);
        end
        for (int k = 0; k < wn; k++) begin
            checks++;
            if (ga[k] !== ea[k] || gw[k] !== ew[k]) begin
                errors++;
                $display("FAIL wrap_wr%0d got %h/%b exp %h/%b",
                         k, ga[k], gw[k], ea[k], ew[k]);
            end
        end
    endtask

    task automatic test_collision();
        int acks_after_write = 0;
        bit prev_w = 0;
        step(1, 0, 0, 12'h0, 32'h0, 32'h0);
        for (int i = 0; i < 16; i++) begin
            step(0, 1, 1, 12'h100, $urandom, $urandom);
            checks++;
            if (rd_ack !== e_ack || ram_addr !== e_addr) begin
                errors++;
                $display("FAIL coll_ack c%0d got %b/%h exp %b/%h",
                         i, rd_ack, ram_addr, e_ack, e_addr);
            end
            checks++;
            if (rd_valid !== e_rdv) begin
                errors++;
                $display("FAIL coll_valid c%0d got %b exp %b",
                         i, rd_valid, e_rdv);
            end
            if (prev_w && rd_ack && ram_addr === 12'h100) acks_after_write++;
            prev_w = ram_we && !rd_ack;
            if (rd_valid) begin
                checks++;
                if (rd_data !== ram_dout) begin
                    errors++;
                    $display("FAIL coll_data got %h exp %h", rd_data, ram_dout);
                end
            end
        end
        checks++;
        if (acks_after_write < 2) begin
            errors++;
            $display("FAIL coll_resume got %0d exp >=2", acks_after_write);
        end
    endtask

    task automatic test_pause();
        int sch, sptr, guard;
        logic [11:0] exp_a;
        step(1, 0, 0, 12'h0, 32'h0, 32'h0);
        guard = 0;
        do begin
            step(0, 1, 0, 12'h0, $urandom, $urandom);
            guard++;
        end while (!(e_isw && guard > 8) && guard < 30);
        checks++;
        if (ram_we !== 1'b1) begin
            errors++; $display("FAIL pause_pre got %b exp 1", ram_we);
        end
        step(0, 1, 0, 12'h0, $urandom, $urandom);
        sch = m_ch;
        sptr = m_ptr[m_ch];
        exp_a = 12'((base1[sch] + sptr) % 4096);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 12'h0, $urandom, $urandom);
            checks++;
            if (ram_we !== 1'b0) begin
                errors++; $display("FAIL pause_off%0d got %b exp 0", i, ram_we);
            end
        end
        for (int i = 0; i <= 5; i++) begin
            step(0, 1, 0, 12'h0, $urandom, $urandom);
            checks++;
            if (ram_we !== (i == 5)) begin
                errors++;
                $display("FAIL pause_we%0d got %b exp %b", i, ram_we, i == 5);
            end
        end
        checks++;
        if (ram_addr !== exp_a || cur_ch !== 1'(sch)) begin
            errors++;
            $display("FAIL pause_resume got %h/%0d exp %h/%0d",
                     ram_addr, cur_ch, exp_a, sch);
        end
    endtask

    task automatic test_reset_in_write();
        int wn = 0;
        int guard = 0;
        step(1, 0, 0, 12'h0, 32'h0, 32'h0);
        while (!(wn >= 3 && next_is_write()) && guard < 40) begin
            step(0, 1, 0, 12'h0, $urandom, $urandom);
            if (ram_we) wn++;
            guard++;
        end
        step(1, 1, 0, 12'h0, $urandom, $urandom);
        checks++;
        if (ram_we !== 1'b0 || wrap !== 2'b00) begin
            errors++;
            $display("FAIL rstw_we got %b/%b exp 0/00", ram_we, wrap);
        end
        step(0, 1, 0, 12'h0, 32'h5A, 32'h0);
        checks++;
        if (wr_ptr !== 4'h0 || cur_ch !== 1'b0) begin
            errors++;
            $display("FAIL rstw_ptrs got %h/%b exp 0/0", wr_ptr, cur_ch);
        end
        for (int i = 1; i <= 5; i++) begin
            step(0, 1, 0, 12'h0, 32'h5A, 32'h0);
            checks++;
            if (ram_we !== (i == 5)) begin
                errors++;
                $display("FAIL rstw_we%0d got %b exp %b", i, ram_we, i == 5);
            end
        end
        checks++;
        if (ram_addr !== 12'h801 || ram_din !== 32'h5A) begin
            errors++;
            $display("FAIL rstw_first got %h/%h exp 801/5a", ram_addr, ram_din);
        end
    endtask

    task automatic test_modular();
        logic [11:0] ea[4] = '{12'hFFE, 12'hFFF, 12'h000, 12'hFFE};
        logic [11:0] ga[4];
        int wn = 0;
        step(1, 0, 0, 12'h0, 32'h0, 32'h0);
        for (int i = 0; i < 40 && wn < 4; i++) begin
            step(0, 1, 0, 12'h0, $urandom, $urandom);
            if (ram_we2 && cur_ch2 == 1'b0) begin
                ga[wn] = ram_addr2;
                wn++;
            end
        end
        checks++;
        if (wn != 4) begin
            errors++; $display("FAIL mod_count got %0d exp 4", wn);
        end
        for (int k = 0; k < wn; k++) begin
            checks++;
            if (ga[k] !== ea[k]) begin
                errors++;
                $display("FAIL mod_wr%0d got %h exp %h", k, ga[k], ea[k]);
            end
        end
    endtask

    task automatic test_random();
        bit rst, en, req;
        step(1, 0, 0, 12'h0, 32'h0, 32'h0);
        for (int i = 0; i < 800; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            en = ($urandom_range(0, 7) != 0);
            req = $urandom_range(0, 1);
            step(rst, en, req, 12'($urandom), $urandom, $urandom);
            checks++;
            if (ram_we !== e_we || ram_addr !== e_addr
                || ram_addr2 !== e_addr2) begin
                errors++;
                $display("FAIL rnd_wr c%0d got %b/%h/%h exp %b/%h/%h", cyc,
                         ram_we, ram_addr, ram_addr2, e_we, e_addr, e_addr2);
            end
            if (e_we) begin
                checks++;
                if (ram_din !== m_sample) begin
                    errors++;
                    $display("FAIL rnd_din c%0d got %h exp %h",
                             cyc, ram_din, m_sample);
                end
            end
            checks++;
            if (rd_ack !== e_ack || rd_valid !== e_rdv) begin
                errors++;
                $display("FAIL rnd_rd c%0d got %b/%b exp %b/%b",
                         cyc, rd_ack, rd_valid, e_ack, e_rdv);
            end
            checks++;
            if (rd_data !== ram_dout) begin
                errors++;
                $display("FAIL rnd_data c%0d got %h exp %h",
                         cyc, rd_data, ram_dout);
            end
            checks++;
            if (wrap !== e_wrap || wr_ptr !== e_ptr || cur_ch !== e_ch) begin
                errors++;
                $display("FAIL rnd_ptr c%0d got %b/%h/%b exp %b/%h/%b", cyc,
                         wrap, wr_ptr, cur_ch, e_wrap, e_ptr, e_ch);
            end
        end
    endtask

    initial begin
        test_reset();
        test_first_write();
        test_wrap();
        test_collision();
        test_pause();
        test_reset_in_write();
        test_modular();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/adc_sample_scheduler.md
# adc_sample_scheduler

Parametrised multi-channel sample scheduler that stores XADC channel samples into per-channel circular buffers in data RAM port B, time-sharing that port with a display/reader client. It generalises the two-channel EMG/ECG sample control and port-B routing in the top-level wrapper:
- N channels, configurable depth and base addresses.
- Exact-depth wrap (0..DEPTH-1).
- Read/write collision handshake.
- Per-channel write-pointer and wrap outputs, so readers can locate the newest sample.

## Interface
- NUM_CH, 2, number of sampled channels, served round-robin starting at channel 0
- DATA_W, 32, sample and RAM word width
- ADDR_W, 12, RAM port B address width
- DEPTH, 640, entries per channel buffer; must be ≥ 2
- SAMPLE_INTERVAL, 125000, clocks between consecutive write slots; must be ≥ 2. Per-channel period is NUM_CH × SAMPLE_INTERVAL.
- CNT_W, 18, interval counter width; must hold SAMPLE_INTERVAL-1
- BASE_ADDRS, {12'hC7F,12'h801}, packed NUM_CH×ADDR_W base addresses; channel i is in bits [i*ADDR_W +: ADDR_W]
- Derived: PTR_W = clog2(DEPTH), CH_W = max(1, clog2(NUM_CH))

Ports:
- clock  in  1  system clock; single clock domain
- reset  in  1  synchronous, active-high reset
- enable  in  1  sampling run enable
- ch_data  in  NUM_CH×DATA_W  packed channel samples, same slicing as BASE_ADDRS
- rd_req  in  1  reader request; held with rd_addr until acknowledged
- rd_addr  in  ADDR_W  reader address
- rd_ack  out  1  request accepted this cycle
- rd_valid  out  1  rd_data holds the word for the last accepted request
- rd_data  out  DATA_W  equals ram_dout
- ram_we  out  1  port B write enable
- ram_addr  out  ADDR_W  port B address
- ram_din  out  DATA_W  port B write data
- ram_dout  in  DATA_W  port B read data; RAM has 1-cycle synchronous read
- wr_ptr  out  NUM_CH×PTR_W  per-channel index of the next slot to be written
- wrap  out  NUM_CH  one-cycle pulse when a channel writes entry DEPTH-1
- cur_ch  out  CH_W  channel that owns the next write slot

## Operation
- **States:**
  - IDLE: enable low; counter held at 0.
  - RUN: counter increments each cycle.
  - WRITE: one-cycle RAM write slot; counter continues incrementing.
- **Transitions:**
  - IDLE→RUN when enable=1.
  - RUN→WRITE at the edge where counter==SAMPLE_INTERVAL-1. The counter goes to 0 at that edge, and ch_data[cur_ch] is captured into the sample register.
  - WRITE→RUN if enable=1; WRITE→IDLE if enable=0.
  - RUN→IDLE when enable=0. The counter is cleared and the partial interval is discarded.
  - A write already in WRITE always completes.
- **In WRITE:**
  - ram_we=1.
  - ram_addr = (BASE_ADDRS[cur_ch] + wr_ptr[cur_ch]) mod 2^ADDR_W.
  - ram_din = captured sample.
- **At the end of WRITE:**
  - wr_ptr[cur_ch] advances and wraps from DEPTH-1 to 0.
  - cur_ch advances and wraps from NUM_CH-1 to 0.
- **wrap[cur_ch]** is high during the WRITE cycle of entry DEPTH-1.
- **Outside WRITE:**
  - ram_we=0, ram_addr=rd_addr.
  - rd_ack = rd_req combinationally.
  - In WRITE, rd_ack=0 and the reader must hold its request.
- **rd_valid** is registered from rd_ack, so it is high exactly 1 cycle after each ack.
- **IDLE preserves state:** wr_ptr and cur_ch are kept; re-enabling resumes the channel order and buffer positions.
- **Buffer overlap** between channels is not detected; BASE_ADDRS placement is the integrator's responsibility.
- **Reset:**
  - Forces IDLE and clears the counter, wr_ptr, cur_ch, the sample register and rd_valid.
  - ram_we is gated by !reset, so asserting reset during a WRITE cycle suppresses that write.

## Timing
- Reset values: ram_we=0, rd_valid=0, wrap=0, wr_ptr=0, cur_ch=0, ram_din=0. ram_addr=rd_addr and rd_ack=rd_req (rd_ack is gated low while reset is high).
- The first WRITE occurs SAMPLE_INTERVAL+1 cycles after the cycle enable is first sampled high in IDLE: 1 cycle to enter RUN, then SAMPLE_INTERVAL counts.
- Successive WRITE cycles are exactly SAMPLE_INTERVAL clocks apart while enable stays high.
- The sample is captured 1 cycle before it is written. ch_data changes in the WRITE cycle itself do not affect the stored value.
- Read latency: ack cycle N → rd_valid and data in cycle N+1.
- Maximum reader stall: 1 cycle per write slot.

## Test plan
Test parameters: NUM_CH=2, DEPTH=3, SAMPLE_INTERVAL=4, BASE_ADDRS={12'hC7F,12'h801}.
1. Reset, then enable=1 with ch_data={32'hB,32'hA} → ram_we pulses 5 cycles later with addr 0x801, din 0xA. The next pulse comes 4 cycles after that with addr 0xC7F, din 0xB.
2. Run 6 writes → ch0 addresses 0x801, 0x802, 0x803; the 7th write returns to 0x801. wrap[0] pulses only with the 0x803 write; wr_ptr[0] reads 0 afterwards.
3. Hold rd_req=1, rd_addr=0x100 across a write slot → rd_ack=0 and ram_addr=write address in WRITE. rd_ack=1 with ram_addr=0x100 in the next cycle; rd_valid=1 one cycle later with rd_data=ram_dout.
4. Drop enable at counter=2, raise it 3 cycles later → no write in between; the next write comes 5 cycles after re-enable, for the same cur_ch and wr_ptr as before.
5. Assert reset in a WRITE cycle → ram_we=0 that cycle; all pointers are 0 after; the first post-reset write goes to ch0 base.
6. BASE_ADDRS[0]=12'hFFE → ch0 writes go to 0xFFE, 0xFFF, 0x000 (modular wrap), then back to 0xFFE.
